ip_timer: RTL and testbench

//  16-bit memory-mapped timer/counter with an 8-bit register bus.

---
 rtl/ip_timer_pkg.sv | 42 ++++
 rtl/ip_timer_edge_sync.sv | 35 +++
 rtl/ip_timer.sv | 139 +++++++++++++
 tb/tb_ip_timer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_timer_pkg.sv
// Shared constants for the 16-bit register-mapped timer: register addresses,
// control/status bit positions and the prescaler decode.
package ip_timer_pkg;

    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_IEN    = 6'h01;
    localparam logic [5:0] ADDR_STAT   = 6'h02;
    localparam logic [5:0] ADDR_CNT_L  = 6'h03;
    localparam logic [5:0] ADDR_CNT_H  = 6'h04;
    localparam logic [5:0] ADDR_CMP0_L = 6'h05;
    localparam logic [5:0] ADDR_CMP0_H = 6'h06;
    localparam logic [5:0] ADDR_CMP1_L = 6'h07;
    localparam logic [5:0] ADDR_CMP1_H = 6'h08;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_SRC    = 1;
    localparam int CTRL_PSC_LO = 2;
    localparam int CTRL_PSC_HI = 4;
    localparam int CTRL_EDGE   = 5;
    localparam int CTRL_CTC    = 6;

    localparam int STAT_OVF = 0;
    localparam int STAT_CM0 = 1;
    localparam int STAT_CM1 = 2;

    // Low-bit mask of the free-running prescaler; a tick fires when all masked bits are 1.
    function automatic logic [11:0] psc_mask(input logic [2:0] code);
        logic [11:0] m;
        case (code)
            3'd0:    m = 12'h000;
            3'd1:    m = 12'h001;
            3'd2:    m = 12'h003;
            3'd3:    m = 12'h007;
            3'd4:    m = 12'h00F;
            3'd5:    m = 12'h03F;
            3'd6:    m = 12'h0FF;
            default: m = 12'h3FF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ip_timer_edge_sync.sv
// Two-flop synchroniser for the asynchronous count input followed by a
// single-cycle rising/falling edge detector (edge_sel: 0=rising, 1=falling).
module ip_timer_edge_sync (
    input  logic clk,
    input  logic rst_b,
    input  logic async_in,
    input  logic edge_sel,
    output logic edge_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign edge_pulse = edge_sel ? (prev_q & ~sync2_q) : (sync2_q & ~prev_q);

endmodule

// File: rtl/ip_timer.sv
// 16-bit timer/counter with prescaled or external tick source, two compare
// channels, maskable overflow/compare interrupts and a set/clear timer_out.
module ip_timer
    import ip_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_b,
    input  logic [5:0] addr,
    input  logic       wr_en,
    input  logic       mod_en,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       overflow_int,
    output logic       comp_0_match_int,
    output logic       comp_1_match_int,
    output logic       timer_out,
    input  logic       timer_in
);

    logic [6:0]  ctrl_q, ctrl_d;
    logic [2:0]  ien_q,  ien_d;
    logic [2:0]  stat_q, stat_d;
    logic [15:0] cnt_q,  cnt_d;
    logic [15:0] cmp0_q, cmp0_d;
    logic [15:0] cmp1_q, cmp1_d;
    logic [11:0] psc_q,  psc_d;
    logic        tout_q, tout_d;

    logic        wr, rd;
    logic        ext_pulse, psc_tick, tick, step;
    logic        cnt_load, ctc_hit;
    logic [15:0] nxt;
    logic [11:0] mask;
    logic [2:0]  evt, w1c;

    assign wr = mod_en & wr_en;
    assign rd = mod_en & ~wr_en;

    ip_timer_edge_sync u_edge_sync (
        .clk        (clk),
        .rst_b      (rst_b),
        .async_in   (timer_in),
        .edge_sel   (ctrl_q[CTRL_EDGE]),
        .edge_pulse (ext_pulse)
    );

    always_comb begin
        mask     = psc_mask(ctrl_q[CTRL_PSC_HI:CTRL_PSC_LO]);
        psc_tick = ((psc_q & mask) == mask);
        tick     = ctrl_q[CTRL_EN] & (ctrl_q[CTRL_SRC] ? ext_pulse : psc_tick);
        psc_d    = ctrl_q[CTRL_EN] ? psc_q + 12'd1 : 12'd0;
    end

    // A bus load of either counter byte overrides the tick and raises no events.
    always_comb begin
        cnt_load      = wr && (addr == ADDR_CNT_L || addr == ADDR_CNT_H);
        step          = tick && !cnt_load;
        ctc_hit       = ctrl_q[CTRL_CTC] && (cnt_q == cmp1_q);
        nxt           = ctc_hit ? 16'h0000 : cnt_q + 16'd1;
        evt           = 3'b000;
        evt[STAT_OVF] = step && !ctc_hit && (cnt_q == 16'hFFFF);
        evt[STAT_CM0] = step && (nxt == cmp0_q);
        evt[STAT_CM1] = step && (ctc_hit || (!ctrl_q[CTRL_CTC] && nxt == cmp1_q));
        cnt_d         = step ? nxt : cnt_q;
        if (wr && addr == ADDR_CNT_L) cnt_d[7:0]  = wdata;
        if (wr && addr == ADDR_CNT_H) cnt_d[15:8] = wdata;
    end

    always_comb begin
        ctrl_d = ctrl_q;
        ien_d  = ien_q;
        cmp0_d = cmp0_q;
        cmp1_d = cmp1_q;
        w1c    = 3'b000;
        if (wr) begin
            case (addr)
                ADDR_CTRL:   ctrl_d        = wdata[6:0];
                ADDR_IEN:    ien_d         = wdata[2:0];
                ADDR_STAT:   w1c           = wdata[2:0];
                ADDR_CMP0_L: cmp0_d[7:0]   = wdata;
                ADDR_CMP0_H: cmp0_d[15:8]  = wdata;
                ADDR_CMP1_L: cmp1_d[7:0]   = wdata;
                ADDR_CMP1_H: cmp1_d[15:8]  = wdata;
                default:     ;
            endcase
        end
        // Hardware set has priority over a same-cycle write-1-to-clear.
        stat_d = (stat_q & ~w1c) | evt;
        if (evt[STAT_CM1])      tout_d = 1'b0;
        else if (evt[STAT_CM0]) tout_d = 1'b1;
        else                    tout_d = tout_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ctrl_q <= '0;
            ien_q  <= '0;
            stat_q <= '0;
            cnt_q  <= '0;
            cmp0_q <= '0;
            cmp1_q <= '0;
            psc_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            ien_q  <= ien_d;
            stat_q <= stat_d;
            cnt_q  <= cnt_d;
            cmp0_q <= cmp0_d;
            cmp1_q <= cmp1_d;
            psc_q  <= psc_d;
            tout_q <= tout_d;
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (rd) begin
            case (addr)
                ADDR_CTRL:   rdata = {1'b0, ctrl_q};
                ADDR_IEN:    rdata = {5'b0, ien_q};
                ADDR_STAT:   rdata = {5'b0, stat_q};
                ADDR_CNT_L:  rdata = cnt_q[7:0];
                ADDR_CNT_H:  rdata = cnt_q[15:8];
                ADDR_CMP0_L: rdata = cmp0_q[7:0];
                ADDR_CMP0_H: rdata = cmp0_q[15:8];
                ADDR_CMP1_L: rdata = cmp1_q[7:0];
                ADDR_CMP1_H: rdata = cmp1_q[15:8];
                default:     rdata = 8'h00;
            endcase
        end
    end

    assign overflow_int     = stat_q[STAT_OVF] & ien_q[STAT_OVF];
    assign comp_0_match_int = stat_q[STAT_CM0] & ien_q[STAT_CM0];
    assign comp_1_match_int = stat_q[STAT_CM1] & ien_q[STAT_CM1];
    assign timer_out        = tout_q;

endmodule

// File: tb/tb_ip_timer.sv
// Bench for ip_timer: random stimulus compared each cycle against a
// cycle-level behavioural model of the timer's register and counting rules.
module tb_ip_timer;

    logic       clk = 1'b0;
    logic       rst_b = 1'b1;
    logic [5:0] addr = '0;
    logic       wr_en = 1'b0;
    logic       mod_en = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       overflow_int, comp_0_match_int, comp_1_match_int, timer_out;
    logic       timer_in = 1'b0;

    int errors = 0;
    int checks = 0;

    ip_timer dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .addr             (addr),
        .wr_en            (wr_en),
        .mod_en           (mod_en),
        .wdata            (wdata),
        .rdata            (rdata),
        .overflow_int     (overflow_int),
        .comp_0_match_int (comp_0_match_int),
        .comp_1_match_int (comp_1_match_int),
        .timer_out        (timer_out),
        .timer_in         (timer_in)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0]  m_ctrl = '0;
    logic [2:0]  m_ien = '0;
    logic [2:0]  m_stat = '0;
    logic [15:0] m_cnt = '0;
    logic [15:0] m_cmp0 = '0;
    logic [15:0] m_cmp1 = '0;
    logic        m_out = 1'b0;
    int          m_run = 0;
    bit          m_smp[3];
    int          divs[8] = '{1, 2, 4, 8, 16, 64, 256, 1024};

    always @(posedge clk or negedge rst_b) begin : model
        int  div, nxt;
        bit  en, tick, ld, ovf, cm0, cm1;
        if (!rst_b) begin
            m_ctrl = '0; m_ien = '0; m_stat = '0; m_cnt = '0;
            m_cmp0 = '0; m_cmp1 = '0; m_out = 1'b0; m_run = 0;
            m_smp[0] = 0; m_smp[1] = 0; m_smp[2] = 0;
        end else begin
            en  = m_ctrl[0];
            div = divs[m_ctrl[4:2]];
            // m_smp[1] / m_smp[2] are timer_in as seen two and three edges ago
            if (m_ctrl[1])
                tick = en && (m_smp[1] != m_smp[2]) && (m_smp[1] == !m_ctrl[5]);
            else
                tick = en && ((m_run % div) == div - 1);
            ld = mod_en && wr_en && (addr == 6'h03 || addr == 6'h04);
            if (ld) tick = 0;
            ovf = 0; cm0 = 0; cm1 = 0;
            if (tick) begin
                if (m_ctrl[6] && m_cnt == m_cmp1) begin
                    nxt = 0; cm1 = 1;
                end else if (m_cnt == 16'hFFFF) begin
                    nxt = 0; ovf = 1;
                end else begin
                    nxt = int'(m_cnt) + 1;
                end
                if (nxt == int'(m_cmp0)) cm0 = 1;
                if (!m_ctrl[6] && nxt == int'(m_cmp1)) cm1 = 1;
                m_cnt = 16'(nxt);
            end
            if (cm1) m_out = 0;
            else if (cm0) m_out = 1;
            m_run = en ? (m_run + 1) % 4096 : 0;
            m_smp[2] = m_smp[1];
            m_smp[1] = m_smp[0];
            m_smp[0] = timer_in;
            if (mod_en && wr_en) begin
                case (addr)
                    6'h00: m_ctrl = wdata & 8'h7F;
                    6'h01: m_ien = wdata[2:0];
                    6'h02: m_stat = m_stat & ~wdata[2:0];
                    6'h03: m_cnt[7:0] = wdata;
                    6'h04: m_cnt[15:8] = wdata;
                    6'h05: m_cmp0[7:0] = wdata;
                    6'h06: m_cmp0[15:8] = wdata;
                    6'h07: m_cmp1[7:0] = wdata;
                    6'h08: m_cmp1[15:8] = wdata;
                    default: ;
                endcase
            end
            m_stat = m_stat | {cm1, cm0, ovf};
        end
    end

    function automatic logic [7:0] m_rd(input logic [5:0] a);
        case (a)
            6'h00: return m_ctrl;
            6'h01: return {5'b0, m_ien};
            6'h02: return {5'b0, m_stat};
            6'h03: return m_cnt[7:0];
            6'h04: return m_cnt[15:8];
            6'h05: return m_cmp0[7:0];
            6'h06: return m_cmp0[15:8];
            6'h07: return m_cmp1[7:0];
            6'h08: return m_cmp1[15:8];
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst_b = 1'b0; mod_en = 0; wr_en = 0; addr = '0; wdata = '0; timer_in = 0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; mod_en = 1; wr_en = 1;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [7:0] got, output logic [7:0] exp);
        @(negedge clk);
        addr = a; mod_en = 1; wr_en = 0;
        #1;
        got = rdata;
        exp = m_rd(a);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mod_en = 0; wr_en = 0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] got, exp;
        apply_reset();
        #1;
        checks++;
        if ({overflow_int, comp_0_match_int, comp_1_match_int, timer_out} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {overflow_int, comp_0_match_int, comp_1_match_int, timer_out});
        end
        for (int a = 0; a < 64; a++) begin
            bus_read(6'(a), got, exp);
            checks++;
            if (got !== 8'h00 || exp !== 8'h00) begin
                errors++;
                $display("FAIL reset_read[%0h]: got %h expected 00", a, got);
            end
        end
        idle(1);
    endtask

    task automatic test_cmp0();
        apply_reset();
        bus_write(6'h05, 8'h10);
        bus_write(6'h06, 8'h00);
        bus_write(6'h01, 8'h02);
        bus_write(6'h00, 8'h01);
        for (int i = 0; i < 24; i++) begin
            idle(1);
            #1;
            checks++;
            if (comp_0_match_int !== (m_stat[1] & m_ien[1]) || timer_out !== m_out) begin
                errors++;
                $display("FAIL cmp0_cycle%0d: got int=%b out=%b expected int=%b out=%b",
                         i, comp_0_match_int, timer_out, m_stat[1] & m_ien[1], m_out);
            end
        end
        checks++;
        if (comp_0_match_int !== 1'b1) begin
            errors++;
            $display("FAIL cmp0_raised: got %b expected 1", comp_0_match_int);
        end
        bus_write(6'h02, 8'h02);
        idle(1);
        #1;
        checks++;
        if (comp_0_match_int !== 1'b0) begin
            errors++;
            $display("FAIL cmp0_w1c: got %b expected 0", comp_0_match_int);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] got, exp;
        apply_reset();
        bus_write(6'h03, 8'hFE);
        bus_write(6'h04, 8'hFF);
        bus_write(6'h01, 8'h01);
        bus_write(6'h00, 8'h01);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            #1;
            checks++;
            if (overflow_int !== (m_stat[0] & m_ien[0])) begin
                errors++;
                $display("FAIL ovf_cycle%0d: got %b expected %b", i, overflow_int, m_stat[0] & m_ien[0]);
            end
        end
        checks++;
        if (overflow_int !== 1'b1) begin
            errors++;
            $display("FAIL ovf_raised: got %b expected 1", overflow_int);
        end
        for (int a = 2; a <= 4; a++) begin
            bus_read(6'(a), got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ovf_read[%0h]: got %h expected %h", a, got, exp);
            end
        end
    endtask

    task automatic test_prescale();
        logic [7:0] got, exp;
        int psc;
        apply_reset();
        bus_write(6'h00, 8'h0D);
        idle(80);
        bus_read(6'h03, got, exp);
        checks++;
        if (got !== 8'h0A || got !== exp) begin
            errors++;
            $display("FAIL psc8_cnt: got %h expected 0a (model %h)", got, exp);
        end
        for (int k = 0; k < 4; k++) begin
            psc = $urandom_range(0, 7);
            bus_write(6'h00, 8'((psc << 2) | 1));
            idle($urandom_range(20, 400));
            for (int a = 3; a <= 4; a++) begin
                bus_read(6'(a), got, exp);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL psc%0d_read[%0h]: got %h expected %h", psc, a, got, exp);
                end
            end
        end
    endtask

    task automatic test_ext_ctc();
        logic [7:0] got, exp;
        int hold, high_cnt;
        bit edge_sel;
        apply_reset();
        edge_sel = 1'($urandom_range(0, 1));
        bus_write(6'h05, 8'd5);
        bus_write(6'h06, 8'd0);
        bus_write(6'h07, 8'd20);
        bus_write(6'h08, 8'd0);
        bus_write(6'h01, 8'h06);
        bus_write(6'h00, 8'h43 | {2'b0, edge_sel, 5'b0});
        hold = 0;
        high_cnt = 0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            mod_en = 0; wr_en = 0;
            if (hold == 0) begin
                timer_in = ~timer_in;
                hold = $urandom_range(2, 12);
            end
            hold--;
            #1;
            checks++;
            if (timer_out !== m_out || comp_0_match_int !== (m_stat[1] & m_ien[1]) ||
                comp_1_match_int !== (m_stat[2] & m_ien[2])) begin
                errors++;
                $display("FAIL ext_cycle%0d: got out=%b c0=%b c1=%b expected out=%b c0=%b c1=%b",
                         i, timer_out, comp_0_match_int, comp_1_match_int,
                         m_out, m_stat[1] & m_ien[1], m_stat[2] & m_ien[2]);
            end
            if (m_cnt > 16'd20) high_cnt++;
        end
        checks++;
        if (high_cnt != 0) begin
            errors++;
            $display("FAIL ext_ctc_bound: got %0d cycles above 20 expected 0", high_cnt);
        end
        bus_read(6'h03, got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL ext_cnt: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_w1c_race();
        logic [7:0] got, exp;
        apply_reset();
        bus_write(6'h07, 8'h30);
        bus_write(6'h08, 8'h00);
        bus_write(6'h03, 8'h2F);
        bus_write(6'h00, 8'h01);
        bus_write(6'h02, 8'h04);
        bus_read(6'h02, got, exp);
        checks++;
        if (got[2] !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL w1c_race: got %h expected %h with bit2 set", got, exp);
        end
        bus_write(6'h02, 8'h04);
        bus_read(6'h02, got, exp);
        checks++;
        if (got[2] !== 1'b0 || got !== exp) begin
            errors++;
            $display("FAIL w1c_plain: got %h expected %h with bit2 clear", got, exp);
        end
        bus_write(6'h00, 8'h00);
        bus_read(6'h03, got, exp);
        idle(15);
        bus_read(6'h03, exp, got);
        checks++;
        if (exp !== got || m_rd(6'h03) !== exp) begin
            errors++;
            $display("FAIL en_freeze: got %h expected %h", exp, got);
        end
        checks++;
        if (timer_out !== m_out) begin
            errors++;
            $display("FAIL freeze_out: got %b expected %b", timer_out, m_out);
        end
    endtask

    task automatic test_random_bus();
        logic [7:0] got, exp;
        logic [5:0] a;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 8));
            if ($urandom_range(0, 1) == 1) begin
                bus_write(a, 8'($urandom));
                #1;
            end else begin
                bus_read(a, got, exp);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL rand_read[%0h]: got %h expected %h", a, got, exp);
                end
            end
            checks++;
            if ({overflow_int, comp_0_match_int, comp_1_match_int, timer_out} !==
                {m_stat[0] & m_ien[0], m_stat[1] & m_ien[1], m_stat[2] & m_ien[2], m_out}) begin
                errors++;
                $display("FAIL rand_outs%0d: got %b expected %b", i,
                         {overflow_int, comp_0_match_int, comp_1_match_int, timer_out},
                         {m_stat[0] & m_ien[0], m_stat[1] & m_ien[1], m_stat[2] & m_ien[2], m_out});
            end
        end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_cmp0();
        test_overflow();
        test_prescale();
        test_ext_ctc();
        test_w1c_race();
        test_random_bus();
        test_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
